// File: rtl/fifo_sched_pkg.sv
// Shared types and defaults for the FIFO access scheduler.
package fifo_sched_pkg;

    // Operation driven onto the FIFO pins in a given cycle
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_e;

    localparam int DEPTH_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic found;
    int   idx;

    // Scan requesters starting at ptr and wrapping; grant the first one found
    always_comb begin
        gnt   = {N{1'b0}};
        found = 1'b0;
        idx   = 32'sd0;
        for (int i = 0; i < N; i++) begin
            idx      = (int'(ptr) + i) % N;
            gnt[idx] = req[idx] && !found;
            found    = found || req[idx];
        end
    end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Arbitrates several writers and one reader onto a single-port FIFO, tracks
// occupancy so the FIFO is never overrun or underrun, and returns read data.
module fifo_access_scheduler
    import fifo_sched_pkg::*;
#(
    parameter  int NWR   = 4,
    parameter  int W     = 4,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (NWR > 1) ? $clog2(NWR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NWR-1:0]   wr_req,
    input  logic [NWR*W-1:0] wr_data,
    output logic [NWR-1:0]   wr_gnt,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic [W-1:0]     rd_data,
    output logic             rd_valid,
    output logic             fifo_wnr,
    output logic             fifo_en,
    output logic [W-1:0]     fifo_in,
    input  logic [W-1:0]     fifo_out,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic [CW-1:0]    count,
    output logic             flag_err
);

    localparam logic [CW-1:0] COUNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(NWR - 1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    op_e            state, next_state, last_op;
    logic [PW-1:0]  rr_ptr, gnt_idx;
    logic [NWR-1:0] arb_gnt;
    logic [W-1:0]   gnt_data;
    logic           write_ok, read_ok, pick_wr, pick_rd;
    logic [CW-1:0]  done_count;
    logic           chk_pending;

    rr_arbiter #(.N(NWR), .PW(PW)) u_arb (
        .req (wr_req),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    // Eligibility and class choice; alternate classes when both can go, no grants during reset
    always_comb begin
        write_ok = (|wr_req) && (count < COUNT_MAX);
        read_ok  = rd_req && (count != COUNT_ZERO);
        pick_rd  = !rst && read_ok && (!write_ok || (last_op == OP_WR));
        pick_wr  = !rst && write_ok && !pick_rd;
        wr_gnt   = pick_wr ? arb_gnt : {NWR{1'b0}};
        rd_gnt   = pick_rd;
    end

    // Decode the winning writer's index and data from the one-hot arbiter output
    always_comb begin
        gnt_idx  = {PW{1'b0}};
        gnt_data = {W{1'b0}};
        for (int k = 0; k < NWR; k++) begin
            gnt_idx  = gnt_idx  | (arb_gnt[k] ? PW'(k) : {PW{1'b0}});
            gnt_data = gnt_data | (arb_gnt[k] ? wr_data[k*W +: W] : {W{1'b0}});
        end
    end

    // Next pin-stage operation follows this cycle's grant
    always_comb begin
        next_state = OP_IDLE;
        case ({pick_wr, pick_rd})
            2'b10:   next_state = OP_WR;
            2'b01:   next_state = OP_RD;
            default: next_state = OP_IDLE;
        endcase
    end

    // Pin-stage state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OP_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FIFO pin registers: enable on any grant; direction and data hold while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_en  <= 1'b0;
            fifo_wnr <= 1'b0;
            fifo_in  <= {W{1'b0}};
        end else begin
            fifo_en <= pick_wr || pick_rd;
            if (pick_wr) begin
                fifo_wnr <= 1'b1;
                fifo_in  <= gnt_data;
            end else if (pick_rd) begin
                fifo_wnr <= 1'b0;
            end
        end
    end

    // Occupancy, class history and round-robin pointer all advance at the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= COUNT_ZERO;
            last_op <= OP_RD;
            rr_ptr  <= {PW{1'b0}};
        end else if (pick_wr) begin
            count   <= count + COUNT_ONE;
            last_op <= OP_WR;
            rr_ptr  <= (gnt_idx == PTR_LAST) ? {PW{1'b0}} : gnt_idx + PTR_ONE;
        end else if (pick_rd) begin
            count   <= count - COUNT_ONE;
            last_op <= OP_RD;
        end
    end

    // Read return: capture the FIFO output on the edge where the read executes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= {W{1'b0}};
        end else begin
            rd_valid <= (state == OP_RD);
            if (state == OP_RD) begin
                rd_data <= fifo_out;
            end
        end
    end

    // Completed-operation count and sticky flag check in the cycle after each operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_count  <= COUNT_ZERO;
            chk_pending <= 1'b0;
            flag_err    <= 1'b0;
        end else begin
            chk_pending <= (state != OP_IDLE);
            case (state)
                OP_WR:   done_count <= done_count + COUNT_ONE;
                OP_RD:   done_count <= done_count - COUNT_ONE;
                default: done_count <= done_count;
            endcase
            if (chk_pending &&
                ((fifo_full  != (done_count == COUNT_MAX)) ||
                 (fifo_empty != (done_count == COUNT_ZERO)))) begin
                flag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Self-checking bench for fifo_access_scheduler with a behavioural FIFO attached.
module tb_fifo_access_scheduler;

    logic        clk, rst;
    logic [3:0]  wr_req;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [3:0]  wr_gnt;
    logic        rd_gnt;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        fifo_wnr, fifo_en;
    logic [3:0]  fifo_in, fifo_out;
    logic        fifo_full, fifo_empty;
    logic [3:0]  count;
    logic        flag_err;
    logic        empty_force;

    int vec  = 0;
    int errs = 0;

    fifo_access_scheduler #(.NWR(4), .W(4), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_wnr(fifo_wnr), .fifo_en(fifo_en), .fifo_in(fifo_in), .fifo_out(fifo_out),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .count(count), .flag_err(flag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8x4 single-port FIFO with show-ahead output
    logic [3:0] fmem [8];
    logic [2:0] fwp, frp;
    int         fcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fwp <= 3'd0; frp <= 3'd0; fcnt <= 0;
        end else if (fifo_en) begin
            if (fifo_wnr) begin
                fmem[fwp] <= fifo_in; fwp <= fwp + 3'd1; fcnt <= fcnt + 1;
            end else begin
                frp <= frp + 3'd1; fcnt <= fcnt - 1;
            end
        end
    end
    assign fifo_out   = fmem[frp];
    assign fifo_full  = (fcnt == 8);
    assign fifo_empty = (fcnt == 0) || empty_force;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_req = 4'd0; rd_req = 1'b0; wr_data = 16'd0; empty_force = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_req = 4'hF; wr_data = 16'h1234; rd_req = 1'b1; empty_force = 1'b0;
        @(negedge clk);
        vec++;
        if ({wr_gnt, rd_gnt, fifo_en, fifo_wnr, fifo_in, rd_data, rd_valid, count, flag_err} !== 21'd0) begin
            errs++;
            $display("FAIL reset_state: got %h expected 0",
                     {wr_gnt, rd_gnt, fifo_en, fifo_wnr, fifo_in, rd_data, rd_valid, count, flag_err});
        end
        do_reset();
    endtask

    task automatic test_single_write();
        do_reset();
        wr_req = 4'b0001; wr_data[3:0] = 4'h3;
        @(negedge clk);
        vec++;
        if ({wr_gnt, rd_gnt} !== 5'b0001_0) begin
            errs++; $display("FAIL single_grant: got %b expected 00010", {wr_gnt, rd_gnt});
        end
        cyc(); wr_req = 4'd0;
        @(negedge clk);
        vec++;
        if ({fifo_en, fifo_wnr, fifo_in, count} !== 10'b1_1_0011_0001) begin
            errs++; $display("FAIL single_pins: got %b expected 1100110001", {fifo_en, fifo_wnr, fifo_in, count});
        end
        cyc();
        @(negedge clk);
        vec++;
        if ({fifo_en, fifo_wnr, fifo_in} !== 6'b0_1_0011) begin
            errs++; $display("FAIL idle_hold: got %b expected 010011", {fifo_en, fifo_wnr, fifo_in});
        end
    endtask

    task automatic test_rr_order();
        logic [3:0] exp_g;
        do_reset();
        wr_req = 4'hF; wr_data = 16'hDCBA;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            @(negedge clk);
            vec++;
            if (wr_gnt !== exp_g) begin
                errs++; $display("FAIL rr_order[%0d]: got %b expected %b", i, wr_gnt, exp_g);
            end
            cyc();
        end
        wr_req = 4'd0;
        @(negedge clk);
        vec++;
        if ({count, fifo_in} !== {4'd5, 4'hA}) begin
            errs++; $display("FAIL rr_count: got %h expected 5a", {count, fifo_in});
        end
    endtask

    task automatic test_full_empty();
        logic g1, g2, exp_g;
        logic [3:0] nexp;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_req = 4'b0001; wr_data[3:0] = 4'(i);
            @(negedge clk);
            vec++;
            if (wr_gnt !== 4'b0001) begin
                errs++; $display("FAIL fill_grant[%0d]: got %b expected 0001", i, wr_gnt);
            end
            cyc();
        end
        wr_data[3:0] = 4'h9;
        @(negedge clk);
        vec++;
        if ({wr_gnt, count} !== {4'd0, 4'd8}) begin
            errs++; $display("FAIL full_block: got %h expected 08", {wr_gnt, count});
        end
        cyc(); wr_req = 4'd0; rd_req = 1'b1;
        g1 = 1'b0; g2 = 1'b0; nexp = 4'd0;
        for (int c = 0; c < 12; c++) begin
            exp_g = (c < 8);
            @(negedge clk);
            vec++;
            if (rd_gnt !== exp_g) begin
                errs++; $display("FAIL drain_gnt[%0d]: got %b expected %b", c, rd_gnt, exp_g);
            end
            vec++;
            if (rd_valid !== g2) begin
                errs++; $display("FAIL drain_valid[%0d]: got %b expected %b", c, rd_valid, g2);
            end
            if (g2) begin
                vec++;
                if (rd_data !== nexp) begin
                    errs++; $display("FAIL drain_data[%0d]: got %h expected %h", c, rd_data, nexp);
                end
                nexp = nexp + 4'd1;
            end
            g2 = g1; g1 = exp_g;
            cyc();
        end
        rd_req = 1'b0;
        @(negedge clk);
        vec++;
        if (count !== 4'd0) begin
            errs++; $display("FAIL drain_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_alternate();
        logic exp_rd;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_req = 4'b0010; wr_data[7:4] = 4'(5 + i);
            cyc();
        end
        wr_req = 4'b0010; wr_data[7:4] = 4'hE; rd_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_rd = (c % 2 == 0);
            @(negedge clk);
            vec++;
            if ({wr_gnt, rd_gnt} !== {(exp_rd ? 4'b0000 : 4'b0010), exp_rd}) begin
                errs++; $display("FAIL alt_grant[%0d]: got %b rd_expected %b", c, {wr_gnt, rd_gnt}, exp_rd);
            end
            vec++;
            if (count !== (exp_rd ? 4'd4 : 4'd3)) begin
                errs++; $display("FAIL alt_count[%0d]: got %0d expected %0d", c, count, exp_rd ? 4 : 3);
            end
            if (c == 2) begin
                vec++;
                if ({rd_valid, rd_data} !== {1'b1, 4'h5}) begin
                    errs++; $display("FAIL alt_data: got %h expected 15", {rd_valid, rd_data});
                end
            end
            cyc();
        end
        wr_req = 4'd0; rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_req = 4'b0100; wr_data[11:8] = 4'(i + 1);
            cyc();
        end
        wr_req = 4'd0; rd_req = 1'b1;
        cyc(); cyc();
        vec++;
        if ({rd_valid, rd_data} !== {1'b1, 4'h1}) begin
            errs++; $display("FAIL mid_read_valid: got %h expected 11", {rd_valid, rd_data});
        end
        rst = 1'b1;
        #1;
        vec++;
        if ({wr_gnt, rd_gnt, fifo_en, fifo_wnr, fifo_in, rd_data, rd_valid, count, flag_err} !== 21'd0) begin
            errs++;
            $display("FAIL mid_reset: got %h expected 0",
                     {wr_gnt, rd_gnt, fifo_en, fifo_wnr, fifo_in, rd_data, rd_valid, count, flag_err});
        end
        cyc(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vec++;
            if ({rd_valid, rd_gnt, fifo_en} !== 3'b000) begin
                errs++; $display("FAIL post_reset[%0d]: got %b expected 000", c, {rd_valid, rd_gnt, fifo_en});
            end
            cyc();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_flag_err();
        do_reset();
        wr_req = 4'b1000; wr_data[15:12] = 4'h7; cyc();
        wr_data[15:12] = 4'h8; cyc();
        wr_req = 4'd0; cyc(); cyc();
        @(negedge clk);
        vec++;
        if ({count, flag_err} !== {4'd2, 1'b0}) begin
            errs++; $display("FAIL flag_clean: got %h expected 04", {count, flag_err});
        end
        cyc();
        empty_force = 1'b1; wr_req = 4'b1000; wr_data[15:12] = 4'h9;
        cyc(); wr_req = 4'd0; cyc(); cyc();
        @(negedge clk);
        vec++;
        if (flag_err !== 1'b1) begin
            errs++; $display("FAIL flag_set: got %b expected 1", flag_err);
        end
        cyc(); empty_force = 1'b0;
        cyc(); cyc(); cyc();
        @(negedge clk);
        vec++;
        if (flag_err !== 1'b1) begin
            errs++; $display("FAIL flag_sticky: got %b expected 1", flag_err);
        end
        rst = 1'b1; #1;
        vec++;
        if (flag_err !== 1'b0) begin
            errs++; $display("FAIL flag_clear: got %b expected 0", flag_err);
        end
        cyc(); rst = 1'b0;
    endtask

    task automatic test_random();
        int mcount, mptr, wk, k, wrate, rrate;
        bit mlast_wr, do_wr, do_rd, wel, rel, found;
        logic [3:0] q[$];
        logic e_en, e_wnr, rv1, rv2;
        logic [3:0] e_in, rd1, e_rdata, ew;
        do_reset();
        mcount = 0; mptr = 0; mlast_wr = 1'b0; q.delete();
        e_en = 1'b0; e_wnr = 1'b0; e_in = 4'd0; rv1 = 1'b0; rv2 = 1'b0; rd1 = 4'd0; e_rdata = 4'd0;
        for (int n = 0; n < 400; n++) begin
            wrate = (n < 200) ? 3 : 1;
            rrate = (n < 200) ? 1 : 3;
            for (int j = 0; j < 4; j++) begin
                if (!wr_req[j] && ($urandom_range(0, 7) < wrate)) begin
                    wr_req[j] = 1'b1; wr_data[j*4 +: 4] = 4'($urandom);
                end
            end
            if (!rd_req && ($urandom_range(0, 3) < rrate)) rd_req = 1'b1;
            @(negedge clk);
            vec++;
            if ({fifo_en, fifo_wnr, fifo_in} !== {e_en, e_wnr, e_in}) begin
                errs++; $display("FAIL rnd_pins[%0d]: got %b expected %b", n, {fifo_en, fifo_wnr, fifo_in}, {e_en, e_wnr, e_in});
            end
            vec++;
            if ({rd_valid, rd_data} !== {rv2, e_rdata}) begin
                errs++; $display("FAIL rnd_read[%0d]: got %h expected %h", n, {rd_valid, rd_data}, {rv2, e_rdata});
            end
            vec++;
            if (int'(count) != mcount) begin
                errs++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, count, mcount);
            end
            wel = (wr_req != 4'd0) && (mcount < 8);
            rel = rd_req && (mcount > 0);
            do_rd = rel && (!wel || mlast_wr);
            do_wr = wel && !do_rd;
            ew = 4'd0; wk = 0; found = 1'b0;
            if (do_wr) begin
                for (int i = 0; i < 4; i++) begin
                    k = (mptr + i) % 4;
                    if (!found && wr_req[k]) begin
                        ew[k] = 1'b1; wk = k; found = 1'b1;
                    end
                end
            end
            vec++;
            if ({wr_gnt, rd_gnt} !== {ew, do_rd}) begin
                errs++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, {wr_gnt, rd_gnt}, {ew, do_rd});
            end
            rv2 = rv1;
            if (rv1) e_rdata = rd1;
            rv1 = do_rd;
            e_en = do_wr || do_rd;
            if (do_rd) begin
                rd1 = q.pop_front(); mcount--; mlast_wr = 1'b0; e_wnr = 1'b0;
            end
            if (do_wr) begin
                e_wnr = 1'b1; e_in = wr_data[wk*4 +: 4]; q.push_back(e_in);
                mcount++; mlast_wr = 1'b1; mptr = (wk + 1) % 4;
            end
            cyc();
            if (do_wr) wr_req[wk] = 1'b0;
            if (do_rd) rd_req = 1'b0;
        end
        wr_req = 4'd0; rd_req = 1'b0;
        @(negedge clk);
        vec++;
        if (flag_err !== 1'b0) begin
            errs++; $display("FAIL rnd_flag: got %b expected 0", flag_err);
        end
    endtask

    initial begin
        rst = 1'b1; wr_req = 4'd0; wr_data = 16'd0; rd_req = 1'b0; empty_force = 1'b0;
        test_reset();
        test_single_write();
        test_rr_order();
        test_full_empty();
        test_alternate();
        test_reset_mid_read();
        test_flag_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
